// File: rtl/visitor_direction_counter_if.sv
// Sensor inputs and occupancy outputs of the visitor direction counter.
interface visitor_direction_counter_if;
  logic       sens_a;
  logic       sens_b;
  logic [7:0] count;
  logic       entry_p;
  logic       exit_p;
  logic       full;
  logic       empty;
  logic       err;

  modport master (
    output sens_a, sens_b,
    input  count, entry_p, exit_p, full, empty, err
  );

  modport slave (
    input  sens_a, sens_b,
    output count, entry_p, exit_p, full, empty, err
  );
endinterface

// File: rtl/visitor_direction_counter.sv
// Two-beam doorway occupancy counter: synchronise and debounce both beams, track
// the A/B passage order with an FSM and keep a saturating occupancy count.
module visitor_direction_counter #(
  parameter int MAX_COUNT  = 99,
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT    = 1000
) (
  input logic                        clk,
  input logic                        rst,
  visitor_direction_counter_if.slave bus
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    MAX_CNT  = 8'(MAX_COUNT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    A1       = 3'd1,
    AB_A     = 3'd2,
    B2       = 3'd3,
    B1       = 3'd4,
    AB_B     = 3'd5,
    A2       = 3'd6,
    WAIT_CLR = 3'd7
  } state_e;

  logic [1:0]    sync_a_q, sync_b_q;
  logic [DW-1:0] run_a_q, run_b_q;
  logic          da_q, db_q;
  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    count_q, count_d;
  logic          entry_p_q, entry_p_d;
  logic          exit_p_q, exit_p_d;
  logic          err_q, err_d;
  logic          entry_ev_s, exit_ev_s, evt_err_s, tmo_err_s;
  logic          pulse_s;
  logic [8:0]    dec_s;

  // Synchroniser and debouncer for both beams.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a_q <= 2'b00;
      sync_b_q <= 2'b00;
      run_a_q  <= '0;
      run_b_q  <= '0;
      da_q     <= 1'b0;
      db_q     <= 1'b0;
    end else begin
      sync_a_q <= {sync_a_q[0], bus.sens_a};
      sync_b_q <= {sync_b_q[0], bus.sens_b};
      if (sync_a_q[1] == da_q) begin
        run_a_q <= '0;
      end else if (run_a_q == DEB_LAST) begin
        da_q    <= sync_a_q[1];
        run_a_q <= '0;
      end else begin
        run_a_q <= run_a_q + DW'(1);
      end
      if (sync_b_q[1] == db_q) begin
        run_b_q <= '0;
      end else if (run_b_q == DEB_LAST) begin
        db_q    <= sync_b_q[1];
        run_b_q <= '0;
      end else begin
        run_b_q <= run_b_q + DW'(1);
      end
    end
  end

  // An event pulse just fired: IDLE waits a cycle so no two pulses are adjacent.
  assign pulse_s = entry_p_q | exit_p_q | err_q;

  // Passage FSM next state, passage events and timeout.
  always_comb begin
    state_d    = state_q;
    entry_ev_s = 1'b0;
    exit_ev_s  = 1'b0;
    evt_err_s  = 1'b0;
    tmo_err_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pulse_s)             state_d = IDLE;
        else if (da_q && !db_q)  state_d = A1;
        else if (!da_q && db_q)  state_d = B1;
        else if (da_q && db_q) begin
          state_d   = WAIT_CLR;
          evt_err_s = 1'b1;
        end else                 state_d = IDLE;
      end
      A1: begin
        if (da_q && db_q)        state_d = AB_A;
        else if (!da_q && !db_q) state_d = IDLE;
        else                     state_d = A1;
      end
      AB_A: begin
        if (!da_q && db_q)       state_d = B2;
        else if (da_q && !db_q)  state_d = A1;
        else                     state_d = AB_A;
      end
      B2: begin
        if (!da_q && !db_q) begin
          state_d    = IDLE;
          entry_ev_s = 1'b1;
        end else if (da_q)       state_d = AB_A;
        else                     state_d = B2;
      end
      B1: begin
        if (da_q && db_q)        state_d = AB_B;
        else if (!da_q && !db_q) state_d = IDLE;
        else                     state_d = B1;
      end
      AB_B: begin
        if (da_q && !db_q)       state_d = A2;
        else if (!da_q && db_q)  state_d = B1;
        else                     state_d = AB_B;
      end
      A2: begin
        if (!da_q && !db_q) begin
          state_d   = IDLE;
          exit_ev_s = 1'b1;
        end else if (db_q)       state_d = AB_B;
        else                     state_d = A2;
      end
      WAIT_CLR: begin
        if (!da_q && !db_q)      state_d = IDLE;
        else                     state_d = WAIT_CLR;
      end
      default:                   state_d = IDLE;
    endcase

    if ((state_q != IDLE) && (state_q != WAIT_CLR) &&
        (state_d == state_q) && (tmo_q == TMO_LAST)) begin
      state_d   = WAIT_CLR;
      tmo_err_s = 1'b1;
    end else begin
      tmo_err_s = 1'b0;
    end

    if (state_d != state_q)                          tmo_d = '0;
    else if ((state_q != IDLE) && (state_q != WAIT_CLR)) tmo_d = tmo_q + TW'(1);
    else                                             tmo_d = '0;
  end

  // Borrow out of the decrement flags an exit with nobody inside.
  assign dec_s = {1'b0, count_q} - 9'd1;

  // Occupancy update and event pulses.
  always_comb begin
    count_d   = count_q;
    entry_p_d = 1'b0;
    exit_p_d  = 1'b0;
    err_d     = evt_err_s | tmo_err_s;
    if (entry_ev_s) begin
      if (count_q < MAX_CNT) begin
        count_d   = count_q + 8'd1;
        entry_p_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (exit_ev_s) begin
      if (!dec_s[8]) begin
        count_d  = dec_s[7:0];
        exit_p_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      count_d = count_q;
    end
  end

  // State, timeout and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      count_q   <= 8'd0;
      entry_p_q <= 1'b0;
      exit_p_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      count_q   <= count_d;
      entry_p_q <= entry_p_d;
      exit_p_q  <= exit_p_d;
      err_q     <= err_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.entry_p = entry_p_q;
  assign bus.exit_p  = exit_p_q;
  assign bus.err     = err_q;
  assign bus.full    = (count_q == MAX_CNT);
  assign bus.empty   = (count_q == 8'd0);

endmodule

// File: doc/visitor_direction_counter.md
VISITOR_DIRECTION_COUNTER -- requirements
Module: visitor_direction_counter

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 99: occupancy saturation limit, 1..255.
REQ-002 SHALL have parameter DEB_CYCLES, default 4: consecutive identical synchronised samples needed to accept a sensor change.
REQ-003 SHALL have parameter TIMEOUT, default 1000: maximum cycles a passage may stay incomplete.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset: synchronous, active-high.
REQ-006 sens_a  input  1  outer beam sensor, raw and asynchronous, 1 = beam broken.
REQ-007 sens_b  input  1  inner beam sensor, raw and asynchronous, 1 = beam broken.
REQ-008 count  output  8  current occupancy, binary, registered.
REQ-009 entry_p  output  1  one-cycle pulse: entry accepted.
REQ-010 exit_p  output  1  one-cycle pulse: exit accepted.
REQ-011 full  output  1  count == MAX_COUNT.
REQ-012 empty  output  1  count == 0.
REQ-013 err  output  1  one-cycle pulse: rejected event (saturation, timeout or simultaneous break).

Function
REQ-014 Each sensor SHALL pass through a 2-flop synchroniser, then a debouncer.
REQ-015 Debounced value SHALL change only after DEB_CYCLES consecutive synchronised samples differ from it; any agreeing sample restarts the run counter.
REQ-016 Total latency from a raw edge to a debounced edge SHALL be 2 + DEB_CYCLES cycles.
REQ-017 The FSM SHALL operate on debounced values (da, db) and have states IDLE, A1, AB_A, B2, B1, AB_B, A2, WAIT_CLR.
REQ-018 IDLE SHALL transition as follows:
- da&!db -> A1
- !da&db -> B1
- da&db -> WAIT_CLR, with err pulse
REQ-019 Entry path SHALL transition as follows:
- A1: da&db -> AB_A; !da&!db -> IDLE (abort, no count)
- AB_A: !da&db -> B2; da&!db -> A1 (backtrack)
- B2: !da&!db -> IDLE with entry event; da -> AB_A
REQ-020 Exit path SHALL mirror REQ-019 with a/b swapped (B1, AB_B, A2) and SHALL produce an exit event.
REQ-021 Any non-IDLE, non-WAIT_CLR state held TIMEOUT consecutive cycles SHALL go to WAIT_CLR with an err pulse and no count change.
REQ-022 The timeout counter SHALL clear on every state change.
REQ-023 WAIT_CLR SHALL return to IDLE only when !da&!db.
REQ-024 On an entry event with count < MAX_COUNT: count SHALL increment and entry_p = 1 on the same clock edge as the FSM returns to IDLE.
REQ-025 On an entry event with count == MAX_COUNT: count SHALL hold, entry_p = 0, err = 1.
REQ-026 On an exit event with count > 0: count SHALL decrement and exit_p = 1 on the same edge.
REQ-027 On an exit event with count == 0: count SHALL hold, exit_p = 0, err = 1.
REQ-028 Decrement SHALL be computed as count minus 1, with borrow used only for underflow detection; count SHALL never wrap.
REQ-029 full and empty SHALL be combinational decodes of the registered count.
REQ-030 entry_p, exit_p and err SHALL be mutually exclusive and SHALL never be high two consecutive cycles.
REQ-031 At most one count change SHALL occur per cycle.

Reset
REQ-032 While rst = 1 at a clock edge, the following SHALL clear: synchronisers, debounced values (to 0), run counters, timeout counter, FSM (to IDLE), count (to 0), entry_p, exit_p and err.
REQ-033 Immediately after reset, full = 0 (MAX_COUNT >= 1) and empty = 1.
REQ-034 Reset asserted mid-passage SHALL discard the passage; a sensor still held high after reset SHALL be treated as a new break.
REQ-035 No output SHALL depend on the pre-reset state.

Verification
REQ-036 Bench SHALL cover these directed scenarios (DEB_CYCLES=4, MAX_COUNT=3, TIMEOUT=50):
- Entry: raw A, then AB, then B, then clear, each held 10 cycles -> entry_p one pulse, count 0->1, empty 1->0.
- Exit: with count=1, drive B, BA, A, clear -> exit_p one pulse, count 1->0, empty=1. Then repeat the exit -> err pulse, count stays 0.
- Saturation: 4 entries -> count 1,2,3; full=1 after the third; fourth entry gives err, count stays 3.
- Glitch and backtrack: A pulse 3 cycles wide -> no debounced change, no pulse. Also A, AB, A, clear -> no count change.
- Timeout and simultaneous: A held 60 cycles -> err at cycle 50 after reaching A1, then WAIT_CLR until clear. A and B raised on the same cycle -> err, no count.
- Reset mid-passage: rst for 1 cycle while in AB_A with count=2 -> count=0, no pulse, FSM IDLE.
